// File: rtl/spi_pkg.sv
// Shared types and defaults for the parametrised SPI master.
//   spi_state_e : transfer FSM states
//   spi_mode_t  : latched SCLK polarity / phase pair
package spi_pkg;

    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_NUM_CS    = 4;
    localparam int unsigned DEF_CLK_DIV_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAD  = 3'd1,
        XFER  = 3'd2,
        TRAIL = 3'd3,
        DONE  = 3'd4
    } spi_state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK timing generator: counts H = div+1 clk cycles per half-period and
// classifies each half-period end as a leading or trailing SCLK edge.
//   clk, rst_n     : system clock, async active-low reset
//   en             : count half-periods (LEAD/XFER/TRAIL)
//   edge_en        : half-period ends are SCLK edges (XFER only)
//   div            : latched divider, H = div+1
//   tick_c         : last cycle of the current half-period
//   lead_edge_c    : tick that is a leading SCLK edge
//   trail_edge_c   : tick that is a trailing SCLK edge
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV_W = DEF_CLK_DIV_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 edge_en,
    input  logic [CLK_DIV_W-1:0] div,
    output logic                 tick_c,
    output logic                 lead_edge_c,
    output logic                 trail_edge_c
);

    logic [CLK_DIV_W-1:0] cnt_q;
    logic                 phase_q;

    // Equality compare to div means div at its maximum never wraps the counter.
    assign tick_c       = en && (cnt_q == div);
    assign lead_edge_c  = tick_c && edge_en && !phase_q;
    assign trail_edge_c = tick_c && edge_en && phase_q;

    // Half-period counter, restarted at every phase boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!en || tick_c) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CLK_DIV_W'(1);
        end
    end

    // Leading/trailing alternation; always starts on a leading edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= 1'b0;
        end else if (!edge_en) begin
            phase_q <= 1'b0;
        end else if (tick_c) begin
            phase_q <= ~phase_q;
        end
    end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised SPI master with start/busy/done handshake, CPOL/CPHA modes,
// programmable SCLK divider and one-hot active-low chip selects.
//   clk, rst_n : system clock, async active-low reset
//   start      : transfer request, accepted in IDLE only
//   tx_data    : word to send, MSB first
//   cs_sel     : slave index; out-of-range runs the transfer with no CS asserted
//   cpol, cpha : SPI mode
//   clk_div    : SCLK half-period H = clk_div+1 clk cycles
//   busy       : transfer in progress
//   done       : one-cycle pulse, rx_data valid
//   rx_data    : last received word
//   spi_sclk, spi_mosi, spi_miso, spi_cs_n : SPI bus
module spi_master_param
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned NUM_CS    = DEF_NUM_CS,
    parameter int unsigned CLK_DIV_W = DEF_CLK_DIV_W,
    localparam int unsigned CS_W     = $clog2((NUM_CS > 1) ? NUM_CS : 2)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [DATA_W-1:0]    tx_data,
    input  logic [CS_W-1:0]      cs_sel,
    input  logic                 cpol,
    input  logic                 cpha,
    input  logic [CLK_DIV_W-1:0] clk_div,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_W-1:0]    rx_data,
    output logic                 spi_sclk,
    output logic                 spi_mosi,
    input  logic                 spi_miso,
    output logic [NUM_CS-1:0]    spi_cs_n
);

    localparam int unsigned CNT_W = $clog2(2 * DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(2 * DATA_W - 1);

    spi_state_e           state_q, state_d;
    spi_mode_t            mode_q, mode_d;
    logic [CLK_DIV_W-1:0] div_q, div_d;
    logic [CS_W-1:0]      sel_q, sel_d;
    logic [DATA_W-1:0]    tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0]    rx_sr_q, rx_sr_d;
    logic [CNT_W-1:0]     edge_cnt_q, edge_cnt_d;

    logic                 busy_d, done_d, sclk_d, mosi_d;
    logic [DATA_W-1:0]    rx_data_d;
    logic [NUM_CS-1:0]    cs_n_d;

    logic                 tick_c, lead_c, trail_c;

    spi_sclk_gen #(.CLK_DIV_W(CLK_DIV_W)) u_sclk_gen (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           ((state_q == LEAD) || (state_q == XFER) || (state_q == TRAIL)),
        .edge_en      (state_q == XFER),
        .div          (div_q),
        .tick_c       (tick_c),
        .lead_edge_c  (lead_c),
        .trail_edge_c (trail_c)
    );

    // Next-state and next-output logic; outputs are registered from these.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        div_d      = div_q;
        sel_d      = sel_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        edge_cnt_d = edge_cnt_q;
        rx_data_d  = rx_data;
        sclk_d     = spi_sclk;
        mosi_d     = spi_mosi;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        cs_n_d     = '1;

        unique case (state_q)
            IDLE: begin
                sclk_d = mode_q.cpol;
                if (start) begin
                    state_d     = LEAD;
                    mode_d.cpol = cpol;
                    mode_d.cpha = cpha;
                    div_d       = clk_div;
                    sel_d       = cs_sel;
                    edge_cnt_d  = '0;
                    sclk_d      = cpol;
                    // cpha=0 presents the MSB before the first edge; cpha=1 on it.
                    if (cpha) begin
                        tx_sr_d = tx_data;
                    end else begin
                        mosi_d  = tx_data[DATA_W-1];
                        tx_sr_d = {tx_data[DATA_W-2:0], 1'b0};
                    end
                end
            end
            LEAD: begin
                if (tick_c) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                if (lead_c || trail_c) begin
                    sclk_d     = ~spi_sclk;
                    edge_cnt_d = edge_cnt_q + CNT_W'(1);
                end
                if ((lead_c && !mode_q.cpha) || (trail_c && mode_q.cpha)) begin
                    rx_sr_d = {rx_sr_q[DATA_W-2:0], spi_miso};
                end
                // No shift after the final trailing edge: MOSI holds the LSB.
                if ((lead_c && mode_q.cpha) ||
                    (trail_c && !mode_q.cpha && (edge_cnt_q != LAST_EDGE))) begin
                    mosi_d  = tx_sr_q[DATA_W-1];
                    tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
                end
                if (trail_c && (edge_cnt_q == LAST_EDGE)) begin
                    state_d = TRAIL;
                end
            end
            TRAIL: begin
                if (tick_c) begin
                    state_d   = DONE;
                    rx_data_d = rx_sr_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == LEAD) || (state_d == XFER) || (state_d == TRAIL);
        done_d = (state_d == DONE);

        // One-hot CS decode; an out-of-range index matches no line.
        if (busy_d) begin
            for (int unsigned i = 0; i < NUM_CS; i++) begin
                if (sel_d == CS_W'(i)) begin
                    cs_n_d[i] = 1'b0;
                end
            end
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mode_q     <= '0;
            div_q      <= '0;
            sel_q      <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            edge_cnt_q <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rx_data    <= '0;
            spi_sclk   <= 1'b0;
            spi_mosi   <= 1'b0;
            spi_cs_n   <= '1;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            div_q      <= div_d;
            sel_q      <= sel_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            edge_cnt_q <= edge_cnt_d;
            busy       <= busy_d;
            done       <= done_d;
            rx_data    <= rx_data_d;
            spi_sclk   <= sclk_d;
            spi_mosi   <= mosi_d;
            spi_cs_n   <= cs_n_d;
        end
    end

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param: an 8-bit / 4-CS instance and a
// 16-bit / 5-CS instance, with MOSI loopback or a mode-aware slave model.
`timescale 1ns/1ps
module tb_spi_master_param;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start8 = 1'b0, pol8 = 1'b0, pha8 = 1'b0;
    logic [7:0]  tx8 = '0, div8 = '0;
    logic [1:0]  sel8 = '0;
    logic        busy8, done8, sclk8, mosi8, miso8;
    logic [7:0]  rx8;
    logic [3:0]  csn8;

    logic        start16 = 1'b0, pol16 = 1'b0, pha16 = 1'b0;
    logic [15:0] tx16 = '0;
    logic [7:0]  div16 = '0;
    logic [2:0]  sel16 = '0;
    logic        busy16, done16, sclk16, mosi16;
    logic [15:0] rx16;
    logic [4:0]  csn16;

    logic        loop8 = 1'b1;
    logic        slv_miso = 1'b0;
    assign miso8 = loop8 ? mosi8 : slv_miso;

    spi_master_param #(.DATA_W(8), .NUM_CS(4), .CLK_DIV_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .tx_data(tx8), .cs_sel(sel8),
        .cpol(pol8), .cpha(pha8), .clk_div(div8), .busy(busy8), .done(done8),
        .rx_data(rx8), .spi_sclk(sclk8), .spi_mosi(mosi8), .spi_miso(miso8),
        .spi_cs_n(csn8)
    );

    spi_master_param #(.DATA_W(16), .NUM_CS(5), .CLK_DIV_W(8)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .tx_data(tx16), .cs_sel(sel16),
        .cpol(pol16), .cpha(pha16), .clk_div(div16), .busy(busy16), .done(done16),
        .rx_data(rx16), .spi_sclk(sclk16), .spi_mosi(mosi16), .spi_miso(mosi16),
        .spi_cs_n(csn16)
    );

    // Slave model on dut8, evaluated mid-cycle so SCLK edges are seen after they settle.
    logic       slv_cpol = 1'b0, slv_cpha = 1'b0, slv_on = 1'b0, slv_prev = 1'b0;
    logic [7:0] slv_tx = '0, slv_rx = '0, slv_tx_init = '0;
    always @(negedge clk) begin
        if (csn8 == 4'hF) begin
            slv_on = 1'b0;
        end else if (!slv_on) begin
            slv_on   = 1'b1;
            slv_tx   = slv_tx_init;
            slv_prev = sclk8;
            if (!slv_cpha) begin
                slv_miso = slv_tx[7];
                slv_tx   = slv_tx << 1;
            end
        end else if (sclk8 != slv_prev) begin
            if (slv_prev == slv_cpol) begin
                if (slv_cpha) begin
                    slv_miso = slv_tx[7];
                    slv_tx   = slv_tx << 1;
                end else begin
                    slv_rx = {slv_rx[6:0], mosi8};
                end
            end else begin
                if (slv_cpha) begin
                    slv_rx = {slv_rx[6:0], mosi8};
                end else begin
                    slv_miso = slv_tx[7];
                    slv_tx   = slv_tx << 1;
                end
            end
            slv_prev = sclk8;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Measurements of the most recent transfer.
    int          m_lat, m_tog, m_rise;
    bit          m_to, m_cs_ok, m_busy_ok;
    logic        m_sclk_first;
    logic [15:0] m_mosi_bits;

    task automatic xfer8(input logic [7:0] tx, input logic [1:0] sel, input logic pol,
                         input logic pha, input logic [7:0] div, input logic [3:0] cs_exp,
                         input bit disturb);
        logic prev;
        prev = 1'b0;
        @(negedge clk);
        tx8 = tx; sel8 = sel; pol8 = pol; pha8 = pha; div8 = div; start8 = 1'b1;
        @(posedge clk);
        m_lat = 0; m_tog = 0; m_rise = 0; m_to = 1'b1; m_cs_ok = 1'b1; m_busy_ok = 1'b1;
        for (int c = 1; c <= 6000; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start8 = 1'b0; m_sclk_first = sclk8; prev = sclk8;
            end
            if (disturb && c == 10) begin
                start8 = 1'b1; tx8 = ~tx; pol8 = ~pol; pha8 = ~pha; div8 = 8'd0; sel8 = sel + 2'd1;
            end
            if (disturb && c == 11) start8 = 1'b0;
            if (sclk8 != prev) begin
                m_tog++;
                if (sclk8) m_rise++;
            end
            prev = sclk8;
            if (done8) begin
                m_lat = c; m_to = 1'b0;
                if (busy8 || csn8 != 4'hF) m_busy_ok = 1'b0;
                break;
            end
            if (csn8 != cs_exp) m_cs_ok = 1'b0;
            if (!busy8) m_busy_ok = 1'b0;
        end
    endtask

    task automatic xfer16(input logic [15:0] tx, input logic [2:0] sel, input logic [4:0] cs_exp);
        logic prev;
        prev = 1'b0;
        @(negedge clk);
        tx16 = tx; sel16 = sel; pol16 = 1'b0; pha16 = 1'b0; div16 = 8'd0; start16 = 1'b1;
        @(posedge clk);
        m_lat = 0; m_tog = 0; m_rise = 0; m_to = 1'b1; m_cs_ok = 1'b1; m_mosi_bits = '0;
        for (int c = 1; c <= 500; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start16 = 1'b0; prev = sclk16;
            end
            if (sclk16 != prev) begin
                m_tog++;
                if (sclk16) begin
                    m_rise++;
                    m_mosi_bits = {m_mosi_bits[14:0], mosi16};
                end
            end
            prev = sclk16;
            if (done16) begin
                m_lat = c; m_to = 1'b0;
                break;
            end
            if (csn16 != cs_exp) m_cs_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy8, done8, sclk8, mosi8, rx8, csn8} !== {4'b0000, 8'h00, 4'hF}) begin
            n_fail++;
            $display("FAIL reset8: busy/done/sclk/mosi/rx/cs_n=%b %b %b %b %h %b, required 0 0 0 0 00 1111",
                     busy8, done8, sclk8, mosi8, rx8, csn8);
        end
        n_checks++;
        if ({busy16, done16, sclk16, mosi16, rx16, csn16} !== {4'b0000, 16'h0000, 5'h1F}) begin
            n_fail++;
            $display("FAIL reset16: busy/done/sclk/mosi/rx/cs_n=%b %b %b %b %h %b, required 0 0 0 0 0000 11111",
                     busy16, done16, sclk16, mosi16, rx16, csn16);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mode0_loopback();
        loop8 = 1'b1;
        xfer8(8'hA5, 2'd2, 1'b0, 1'b0, 8'd1, 4'b1011, 1'b0);
        n_checks++;
        if (m_to || m_lat != 37) begin
            n_fail++; $display("FAIL mode0_latency: got %0d (timeout=%0d), required 37", m_lat, m_to);
        end
        n_checks++;
        if (m_rise != 8) begin
            n_fail++; $display("FAIL mode0_rises: got %0d, required 8", m_rise);
        end
        n_checks++;
        if (rx8 !== 8'hA5) begin
            n_fail++; $display("FAIL mode0_rx: got %h, required a5", rx8);
        end
        n_checks++;
        if (!m_cs_ok || !m_busy_ok) begin
            n_fail++; $display("FAIL mode0_cs_busy: cs_ok=%0d busy_ok=%0d, required 1 1", m_cs_ok, m_busy_ok);
        end
    endtask

    task automatic test_modes();
        loop8 = 1'b0;
        slv_tx_init = 8'h3C;
        for (int m = 1; m <= 3; m++) begin
            slv_cpol = (m >= 2);
            slv_cpha = (m % 2 == 1);
            slv_rx   = '0;
            xfer8(8'hC3, 2'd1, slv_cpol, slv_cpha, 8'd1, 4'b1101, 1'b0);
            n_checks++;
            if (rx8 !== 8'h3C || slv_rx !== 8'hC3) begin
                n_fail++; $display("FAIL mode%0d_data: rx=%h slave=%h, required 3c c3", m, rx8, slv_rx);
            end
            n_checks++;
            if (m_sclk_first !== slv_cpol || sclk8 !== slv_cpol) begin
                n_fail++; $display("FAIL mode%0d_idle: sclk lead=%b done=%b, required %b", m, m_sclk_first, sclk8, slv_cpol);
            end
            n_checks++;
            if (m_to || m_lat != 37 || m_tog != 16) begin
                n_fail++; $display("FAIL mode%0d_timing: lat=%0d toggles=%0d, required 37 16", m, m_lat, m_tog);
            end
        end
        loop8 = 1'b1;
    endtask

    task automatic test_width16();
        xfer16(16'hBEEF, 3'd0, 5'b11110);
        n_checks++;
        if (m_to || m_lat != 35 || m_rise != 16) begin
            n_fail++; $display("FAIL w16_timing: lat=%0d rises=%0d, required 35 16", m_lat, m_rise);
        end
        n_checks++;
        if (m_mosi_bits !== 16'hBEEF || rx16 !== 16'hBEEF) begin
            n_fail++; $display("FAIL w16_data: mosi=%h rx=%h, required beef beef", m_mosi_bits, rx16);
        end
        n_checks++;
        if (!m_cs_ok) begin
            n_fail++; $display("FAIL w16_cs: cs_n not 11110 during transfer, got ok=%0d required 1", m_cs_ok);
        end
    endtask

    task automatic test_ignore_midxfer();
        int extra;
        loop8 = 1'b1;
        xfer8(8'h5A, 2'd2, 1'b0, 1'b0, 8'd1, 4'b1011, 1'b1);
        n_checks++;
        if (m_to || m_lat != 37 || rx8 !== 8'h5A) begin
            n_fail++; $display("FAIL ignore_xfer: lat=%0d rx=%h, required 37 5a", m_lat, rx8);
        end
        n_checks++;
        if (!m_cs_ok || m_tog != 16 || sclk8 !== 1'b0) begin
            n_fail++; $display("FAIL ignore_latched: cs_ok=%0d toggles=%0d sclk=%b, required 1 16 0", m_cs_ok, m_tog, sclk8);
        end
        extra = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done8 || busy8) extra++;
        end
        n_checks++;
        if (extra != 0) begin
            n_fail++; $display("FAIL ignore_extra: busy/done cycles after done=%0d, required 0", extra);
        end
    endtask

    task automatic test_reset_midxfer();
        int tog;
        logic prev;
        loop8 = 1'b1;
        tog = 0;
        @(negedge clk);
        tx8 = 8'h96; sel8 = 2'd0; pol8 = 1'b0; pha8 = 1'b0; div8 = 8'd1; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0; prev = sclk8;
        for (int c = 0; c < 100 && tog < 5; c++) begin
            @(negedge clk);
            if (sclk8 != prev) tog++;
            prev = sclk8;
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (tog != 5 || {busy8, done8, sclk8, mosi8, rx8, csn8} !== {4'b0000, 8'h00, 4'hF}) begin
            n_fail++;
            $display("FAIL reset_mid: edges=%0d busy/done/sclk/mosi/rx/cs_n=%b %b %b %b %h %b, required 5 0 0 0 0 00 1111",
                     tog, busy8, done8, sclk8, mosi8, rx8, csn8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        xfer8(8'h69, 2'd3, 1'b0, 1'b0, 8'd1, 4'b0111, 1'b0);
        n_checks++;
        if (m_to || m_lat != 37 || rx8 !== 8'h69 || !m_cs_ok) begin
            n_fail++; $display("FAIL reset_recover: lat=%0d rx=%h cs_ok=%0d, required 37 69 1", m_lat, rx8, m_cs_ok);
        end
    endtask

    task automatic test_cs_out_of_range();
        for (int s = 5; s <= 7; s += 2) begin
            xfer16(16'h1234, 3'(s), 5'h1F);
            n_checks++;
            if (m_to || !m_cs_ok || m_tog != 32 || m_lat != 35 || rx16 !== 16'h1234) begin
                n_fail++;
                $display("FAIL cs_range%0d: cs_ok=%0d toggles=%0d lat=%0d rx=%h, required 1 32 35 1234",
                         s, m_cs_ok, m_tog, m_lat, rx16);
            end
        end
    endtask

    task automatic test_back_to_back();
        int d1, d2, nd;
        d1 = 0; d2 = 0; nd = 0;
        loop8 = 1'b1;
        @(negedge clk);
        tx8 = 8'h3C; sel8 = 2'd0; pol8 = 1'b0; pha8 = 1'b0; div8 = 8'd0; start8 = 1'b1;
        for (int c = 1; c <= 200 && nd < 2; c++) begin
            @(negedge clk);
            if (done8) begin
                nd++;
                if (nd == 1) d1 = c;
                else begin
                    d2 = c; start8 = 1'b0;
                end
            end
        end
        start8 = 1'b0;
        n_checks++;
        if (d1 != 19 || d2 != 39) begin
            n_fail++; $display("FAIL b2b_timing: done at %0d and %0d, required 19 and 39", d1, d2);
        end
        n_checks++;
        if (rx8 !== 8'h3C) begin
            n_fail++; $display("FAIL b2b_rx: got %h, required 3c", rx8);
        end
        repeat (30) begin
            @(negedge clk);
            if (done8 || busy8) nd++;
        end
        n_checks++;
        if (nd != 2) begin
            n_fail++; $display("FAIL b2b_stop: activity count=%0d, required 2", nd);
        end
    endtask

    task automatic test_max_div();
        loop8 = 1'b1;
        xfer8(8'h81, 2'd0, 1'b0, 1'b0, 8'd255, 4'b1110, 1'b0);
        n_checks++;
        if (m_to || m_lat != 4609 || rx8 !== 8'h81 || m_rise != 8) begin
            n_fail++; $display("FAIL max_div: lat=%0d rx=%h rises=%0d, required 4609 81 8", m_lat, rx8, m_rise);
        end
    endtask

    initial begin
        test_reset();
        test_mode0_loopback();
        test_modes();
        test_width16();
        test_ignore_midxfer();
        test_reset_midxfer();
        test_cs_out_of_range();
        test_back_to_back();
        test_max_div();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
